// File: rtl/regfile_param_pkg.sv
// Shared definitions for the parameterised register file and its clear sequencer.
package regfile_param_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: walks every register index once after reset or on request,
// holding busy high for exactly 2**ADDR_W cycles.
module regfile_clr_seq
    import regfile_param_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              busy,
    output logic [ADDR_W-1:0] clr_idx
);

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    clr_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] idx_reg, idx_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= CLEAR;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    // A request arriving while already clearing is ignored, so the sweep never restarts.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            IDLE: begin
                if (clr_req) begin
                    state_next = CLEAR;
                    idx_next   = '0;
                end
            end
            CLEAR: begin
                idx_next = idx_reg + 1'b1;
                if (idx_reg == LAST_IDX) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = CLEAR;
                idx_next   = '0;
            end
        endcase
    end

    assign busy    = (state_reg == CLEAR);
    assign clr_idx = idx_reg;

endmodule

// File: rtl/regfile_param.sv
// Two-read, one-write register file with optional zero register, optional
// write-to-read forwarding, a debug tap and a sequenced full-array clear.
module regfile_param
    import regfile_param_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_addr_1,
    input  logic [ADDR_W-1:0] read_addr_2,
    output logic [DATA_W-1:0] read_data_1,
    output logic [DATA_W-1:0] read_data_2,
    input  logic              clr_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    // No reset on the array so it maps onto distributed RAM; the sequencer zeroes it instead.
    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_busy;
    logic [ADDR_W-1:0] clr_idx;
    logic              write_hardwired;
    logic              write_ok;

    regfile_clr_seq #(
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk     (clk),
        .rst     (rst),
        .clr_req (clr_req),
        .busy    (clr_busy),
        .clr_idx (clr_idx)
    );

    assign write_hardwired = (ZERO_REG != 0) && (write_addr == '0);
    assign write_ok        = we && !write_hardwired && !clr_busy;

    always_ff @(posedge clk) begin
        if (clr_busy) begin
            mem[clr_idx] <= '0;
        end else if (write_ok) begin
            mem[write_addr] <= write_data;
        end
    end

    // Read ports share one structure; gi selects which address/data pair it serves.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic [DATA_W-1:0] data;

            assign addr = (gi == 0) ? read_addr_1 : read_addr_2;

            always_comb begin
                data = '0;
                if (!clr_busy && !((ZERO_REG != 0) && (addr == '0))) begin
                    if ((BYPASS != 0) && write_ok && (write_addr == addr)) begin
                        data = write_data;
                    end else begin
                        data = mem[addr];
                    end
                end
            end
        end
    endgenerate

    assign read_data_1 = g_rd[0].data;
    assign read_data_2 = g_rd[1].data;

    assign dbg_data = (clr_busy || ((ZERO_REG != 0) && (dbg_addr == '0))) ? '0 : mem[dbg_addr];
    assign busy     = clr_busy;

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench: two register files (defaults, and no-bypass/writable-r0)
// share one stimulus stream and are compared against an array-based model.
module tb_regfile_param;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          we = 1'b0;
    logic          clr_req = 1'b0;
    logic [AW-1:0] write_addr = '0;
    logic [AW-1:0] read_addr_1 = '0;
    logic [AW-1:0] read_addr_2 = '0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] write_data = '0;

    logic [DW-1:0] rd1_a, rd2_a, dbg_a, rd1_b, rd2_b, dbg_b;
    logic          busy_a, busy_b;

    always #5 clk = ~clk;

    regfile_param #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst(rst), .we(we), .write_addr(write_addr), .write_data(write_data),
        .read_addr_1(read_addr_1), .read_addr_2(read_addr_2),
        .read_data_1(rd1_a), .read_data_2(rd2_a), .clr_req(clr_req),
        .dbg_addr(dbg_addr), .dbg_data(dbg_a), .busy(busy_a)
    );

    regfile_param #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst), .we(we), .write_addr(write_addr), .write_data(write_data),
        .read_addr_1(read_addr_1), .read_addr_2(read_addr_2),
        .read_data_1(rd1_b), .read_data_2(rd2_b), .clr_req(clr_req),
        .dbg_addr(dbg_addr), .dbg_data(dbg_b), .busy(busy_b)
    );

    typedef struct packed {
        logic          busy;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] dbg;
    } obs_t;

    typedef struct packed {
        obs_t a;
        obs_t b;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;

    // Reference model: plain arrays plus a count of clear cycles still owed.
    logic [DW-1:0] mdl [2][DEPTH];
    int            clear_left = 0;
    int            clr_pos    = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // k = 0: bypass on, r0 hardwired; k = 1: no bypass, r0 writable.
    function automatic bit hardwired(input int k, input logic [AW-1:0] a);
        return (k == 0) && (a == '0);
    endfunction

    function automatic logic [DW-1:0] model_read(input int k, input logic [AW-1:0] a, input bit use_bypass);
        if (clear_left > 0) return '0;
        if (hardwired(k, a)) return '0;
        if (use_bypass && k == 0 && we && write_addr == a) return write_data;
        return mdl[k][a];
    endfunction

    task automatic model_edge();
        if (rst) begin
            clear_left = DEPTH;
            clr_pos    = 0;
        end else if (clear_left > 0) begin
            for (int k = 0; k < 2; k++) mdl[k][clr_pos] = '0;
            clr_pos++;
            clear_left--;
        end else if (clr_req) begin
            clear_left = DEPTH;
            clr_pos    = 0;
        end else if (we) begin
            for (int k = 0; k < 2; k++)
                if (!hardwired(k, write_addr)) mdl[k][write_addr] = write_data;
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic c, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                         input logic [AW-1:0] d);
        exp_t e;
        @(posedge clk);
        #1;
        model_edge();
        rst = r; we = w; clr_req = c;
        write_addr = wa; write_data = wd;
        read_addr_1 = a1; read_addr_2 = a2; dbg_addr = d;
        if (r) begin
            clear_left = DEPTH;
            clr_pos    = 0;
        end
        e.a.busy = (clear_left > 0);
        e.a.rd1  = model_read(0, a1, 1'b1);
        e.a.rd2  = model_read(0, a2, 1'b1);
        e.a.dbg  = model_read(0, d, 1'b0);
        e.b.busy = (clear_left > 0);
        e.b.rd1  = model_read(1, a1, 1'b0);
        e.b.rd2  = model_read(1, a2, 1'b0);
        e.b.dbg  = model_read(1, d, 1'b0);
        exp_q.push_back(e);
    endtask

    task automatic rnd_cycle(input bit allow_ctl);
        logic [AW-1:0] wa, a1, a2, d;
        logic          r, c, w;
        wa = AW'($urandom_range(0, DEPTH - 1));
        a1 = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
        a2 = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
        d  = AW'($urandom_range(0, DEPTH - 1));
        r  = allow_ctl && ($urandom_range(0, 199) == 0);
        c  = allow_ctl && ($urandom_range(0, 49) == 0);
        w  = 1'($urandom_range(0, 1));
        drive(r, w, c, wa, $urandom, a1, a2, d);
    endtask

    // Runs random (non-control) cycles and returns how many of them showed busy.
    task automatic count_busy(output int n);
        bit done;
        n    = 0;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            rnd_cycle(1'b0);
            @(negedge clk);
            #1;
            if (!busy_a) done = 1;
            else n++;
        end
    endtask

    // Monitor: outputs are combinational, so every cycle presents one observation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("busy_a", {31'b0, busy_a}, {31'b0, e.a.busy});
                check("rd1_a", rd1_a, e.a.rd1);
                check("rd2_a", rd2_a, e.a.rd2);
                check("dbg_a", dbg_a, e.a.dbg);
                check("busy_b", {31'b0, busy_b}, {31'b0, e.b.busy});
                check("rd1_b", rd1_b, e.b.rd1);
                check("rd2_b", rd2_b, e.b.rd2);
                check("dbg_b", dbg_b, e.b.dbg);
            end
        end
    end

    initial begin
        int n;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < DEPTH; i++) mdl[k][i] = '0;

        repeat (2) @(posedge clk);
        repeat (3) drive(1, 0, 0, '0, '0, '0, '0, '0);
        count_busy(n);
        check("busy_len_reset", n, 32);
        for (int i = 0; i < DEPTH; i++)
            drive(0, 0, 0, '0, '0, AW'(i), AW'(DEPTH - 1 - i), AW'(i));
        $display("reset sweep done, busy cycles %0d", n);

        drive(0, 1, 0, AW'(5), 32'hDEADBEEF, '0, '0, '0);
        drive(0, 0, 0, '0, '0, AW'(5), AW'(5), AW'(5));
        @(negedge clk); #1;
        check("r5_port1", rd1_a, 32'hDEADBEEF);
        check("r5_port2", rd2_a, 32'hDEADBEEF);
        drive(0, 1, 0, '0, 32'h1234, '0, '0, '0);
        drive(0, 0, 0, '0, '0, '0, '0, '0);
        @(negedge clk); #1;
        check("r0_zero_a", rd1_a, 32'h0);
        check("r0_written_b", rd1_b, 32'h1234);
        $display("r5 write and r0 write transactions done");

        drive(0, 1, 0, AW'(7), 32'h1111, '0, '0, '0);
        drive(0, 1, 0, AW'(7), 32'hA5A5A5A5, AW'(7), AW'(7), AW'(7));
        @(negedge clk); #1;
        check("bypass_a", rd1_a, 32'hA5A5A5A5);
        check("nobypass_b", rd1_b, 32'h1111);
        check("dbg_nobypass_a", dbg_a, 32'h1111);
        drive(0, 0, 0, '0, '0, AW'(7), AW'(7), AW'(7));
        $display("bypass transaction done");

        for (int i = 1; i < DEPTH; i++)
            drive(0, 1, 0, AW'(i), 32'h100 + 32'(i), AW'(i), AW'(i - 1), AW'(i));
        drive(0, 0, 1, '0, '0, '0, '0, '0);
        count_busy(n);
        check("busy_len_clr", n, 32);
        for (int i = 0; i < DEPTH; i++)
            drive(0, 0, 0, '0, '0, AW'(i), AW'(i), AW'(i));
        $display("fill and clear done, busy cycles %0d", n);

        drive(0, 1, 0, AW'(3), 32'h77, '0, '0, '0);
        drive(0, 0, 1, '0, '0, '0, '0, '0);
        for (int i = 0; i < 10; i++) drive(0, 0, 1, '0, '0, AW'(3), '0, AW'(3));
        drive(1, 0, 0, '0, '0, '0, '0, '0);
        drive(1, 0, 0, '0, '0, '0, '0, '0);
        count_busy(n);
        check("busy_len_abort", n, 32);
        $display("reset mid-clear done, busy cycles %0d", n);

        drive(0, 1, 0, '0, 32'h55, '0, '0, '0);
        drive(0, 0, 0, '0, '0, '0, '0, '0);
        @(negedge clk); #1;
        check("r0_55_b", rd1_b, 32'h55);
        check("dbg0_55_b", dbg_b, 32'h55);
        check("r0_zero_a2", rd1_a, 32'h0);

        for (int i = 0; i < 1500; i++) rnd_cycle(1'b1);
        $display("random phase done");

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 Parameter DATA_W, default 32, width of each register in bits.
REQ-002 Parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter BYPASS, default 1; 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-004 Parameter ZERO_REG, default 1; 1 = register 0 hardwired to zero, 0 = register 0 writable.
REQ-005 Clocking: one clock, clk; reset rst is asynchronous and active-high.
REQ-006 clk  input  1  sole clock; all state updates on the rising edge.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 we  input  1  write enable.
REQ-009 write_addr  input  ADDR_W  write address.
REQ-010 write_data  input  DATA_W  write data.
REQ-011 read_addr_1 / read_addr_2  input  ADDR_W  read port addresses.
REQ-012 read_data_1 / read_data_2  output  DATA_W  combinational read data.
REQ-013 clr_req  input  1  single-cycle pulse requesting a full-array clear.
REQ-014 dbg_addr  input  ADDR_W  debug tap address.
REQ-015 dbg_data  output  DATA_W  debug tap contents (no bypass).
REQ-016 busy  output  1  high while the clear sequence runs.

Function
REQ-017 FSM states: IDLE and CLEAR; the clear index clr_idx is ADDR_W bits wide.
REQ-018 Entry to CLEAR: on reset release, the block is in CLEAR with clr_idx = 0.
REQ-019 Each CLEAR cycle writes zero to register clr_idx, then increments clr_idx.
REQ-020 CLEAR exit: after writing index DEPTH-1, the next state is IDLE; CLEAR lasts exactly DEPTH cycles.
REQ-021 busy = 1 exactly while the state is CLEAR.
REQ-022 clr_req sampled in IDLE moves the FSM to CLEAR with clr_idx = 0 on the next edge; clr_req in CLEAR is ignored, with no restart.
REQ-023 In IDLE, we = 1 with an address that is not hardwired writes write_data at the next rising edge.
REQ-024 Writes to register 0 when ZERO_REG = 1 are dropped.
REQ-025 we during CLEAR is dropped; the write is not queued.
REQ-026 Reads are asynchronous; in IDLE read_data_n = register[read_addr_n].
REQ-027 read_data_n is 0 when read_addr_n = 0 and ZERO_REG = 1.
REQ-028 Bypass: when BYPASS = 1, in IDLE, with we = 1, write_addr = read_addr_n and the address not hardwired, read_data_n = write_data in the same cycle.
REQ-029 Both read ports may bypass simultaneously.
REQ-030 While busy, read_data_1, read_data_2 and dbg_data are all 0.
REQ-031 dbg_data = register[dbg_addr], with the zero rule and no bypass.
REQ-032 Writing and reading the same address with BYPASS = 0 returns the old value until the next edge.

Reset
REQ-033 rst asserted asynchronously forces state = CLEAR, clr_idx = 0 and busy = 1 immediately; array contents are not reset directly.
REQ-034 rst asserted mid-CLEAR or mid-write aborts the operation, and clearing restarts from index 0 after release.
REQ-035 All outputs read 0 from rst assertion until CLEAR completes.

Structure
REQ-036 Shared package holds the FSM state typedef (IDLE, CLEAR) and the default DATA_W and ADDR_W constants.
REQ-037 The clear sequencer (FSM plus index counter) is the sub-module regfile_clr_seq; the storage array and read muxing stay in regfile_param.
REQ-038 The storage array has no reset so that it infers distributed RAM or flops.

Verification
REQ-039 Reset then idle: busy = 1 for exactly 32 cycles (default parameters), then 0, and every register reads 0.
REQ-040 Write 0xDEADBEEF to r5, then read r5 on both ports the next cycle: 0xDEADBEEF; write 0x1234 to r0: r0 still reads 0.
REQ-041 BYPASS = 1, we = 1 to r7 with 0xA5A5A5A5 while read_addr_1 = 7: read_data_1 = 0xA5A5A5A5 in the same cycle; with BYPASS = 0 it shows the old value.
REQ-042 Fill r1..r31 with nonzero values and pulse clr_req: busy is high for 32 cycles, a write attempted mid-clear is dropped, and all registers read 0 afterwards.
REQ-043 Assert rst at clr_idx = 10 of a clear, then release: clearing restarts at 0 and busy lasts a full 32 cycles.
REQ-044 ZERO_REG = 0: write 0x55 to r0 after clear, then read r0 and dbg_addr = 0: both return 0x55.
